stream_mux_rr: RTL and testbench

- Parametrised successor to the team's 2:1 combinational select mux.
- Generalised to CHANNELS inputs of WIDTH bits, each with a valid/ready handshake.
- Two modes: fixed select (legacy behaviour) or round-robin arbitration.
- A single registered output stage feeds a downstream valid/ready consumer. It sits between multiple producers and one shared sink.

---
 rtl/stream_mux_rr_pkg.sv | 35 +++
 rtl/stream_mux_rr_if.sv | 31 +++
 rtl/stream_mux_rr_arbiter.sv | 54 +++++
 rtl/stream_mux_rr.sv | 109 ++++++++++
 tb/tb_stream_mux_rr.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and the wrap-around priority search for the stream mux.
// Optional packet lock is enabled with STREAM_MUX_RR_LOCK_EN.
package stream_mux_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int MAX_CHANNELS = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First requester strictly after 'last', wrapping at n-1 -> 0.
  // Walk distances from far to near so the nearest requester overwrites.
  function automatic rr_pick_t rr_search(input logic [MAX_CHANNELS-1:0] req,
                                         input logic [3:0] last,
                                         input int n);
    rr_pick_t r;
    int c;
    r = '0;
    for (int k = MAX_CHANNELS; k >= 1; k--) begin
      if (k <= n) begin
        c = (int'(last) + k) % n;
        if (req[4'(c)]) begin
          r.found = 1'b1;
          r.idx   = 4'(c);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Producer-side and consumer-side stream signals of the stream mux.
// STREAM_MUX_RR_LOCK_EN adds in_last/out_last.
interface stream_mux_rr_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          out_chan;
`ifdef STREAM_MUX_RR_LOCK_EN
  logic [CHANNELS-1:0]       in_last;
  logic                      out_last;

  modport master (output in_data, in_valid, in_last, out_ready,
                  input  in_ready, out_data, out_valid, out_chan, out_last);
  modport slave  (input  in_data, in_valid, in_last, out_ready,
                  output in_ready, out_data, out_valid, out_chan, out_last);
`else
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, out_chan);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, out_chan);
`endif

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter owning the last-winner pointer and the packet lock.
// The lock path is only exercised when STREAM_MUX_RR_LOCK_EN drives 'lock'.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int  CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  input  logic                lock,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  logic [SEL_W-1:0]        last;
  logic [SEL_W-1:0]        lock_chan;
  logic                    locked;
  logic [MAX_CHANNELS-1:0] req_ext;
  rr_pick_t                pick;

  always_comb begin
    req_ext                 = '0;
    req_ext[CHANNELS-1:0]   = req;
    pick                    = rr_search(req_ext, 4'(last), CHANNELS);
    if (locked) begin
      grant       = lock_chan;
      grant_valid = req[lock_chan];
    end else begin
      grant       = SEL_W'(pick.idx);
      grant_valid = pick.found;
    end
  end

  // A locked beat leaves the pointer alone; it moves when the packet closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= SEL_W'(CHANNELS - 1);
      lock_chan <= '0;
      locked    <= 1'b0;
    end else if (advance) begin
      if (lock) begin
        locked    <= 1'b1;
        lock_chan <= grant;
      end else begin
        locked <= 1'b0;
        last   <= grant;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with fixed-select or round-robin grant and one output register.
// Define STREAM_MUX_RR_LOCK_EN to hold the round-robin grant until in_last.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] select,
  stream_mux_rr_if.slave   bus
);

  logic                load_en;
  logic                grant_valid;
  logic                rr_grant_valid;
  logic                transfer;
  logic                advance;
  logic                lock;
  logic [SEL_W-1:0]    grant;
  logic [SEL_W-1:0]    rr_grant;
  logic [CHANNELS-1:0] ready;
  logic [WIDTH-1:0]    mux_data;
  logic [WIDTH-1:0]    data_q;
  logic                valid_q;
  logic [SEL_W-1:0]    chan_q;
`ifdef STREAM_MUX_RR_LOCK_EN
  logic                mux_last;
  logic                last_q;
`endif

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.in_valid),
    .advance     (advance),
    .lock        (lock),
    .grant       (rr_grant),
    .grant_valid (rr_grant_valid)
  );

  always_comb begin
    load_en = !valid_q || bus.out_ready;
    if (mode == MODE_SELECT) begin
      grant       = select;
      grant_valid = int'(select) < CHANNELS;
    end else begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end
    ready    = '0;
    mux_data = '0;
`ifdef STREAM_MUX_RR_LOCK_EN
    mux_last = 1'b0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (load_en && grant_valid && int'(grant) == i) ready[i] = 1'b1;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (ready[i]) begin
        mux_data = bus.in_data[i*WIDTH +: WIDTH];
`ifdef STREAM_MUX_RR_LOCK_EN
        mux_last = bus.in_last[i];
`endif
      end
    end
    transfer = |(ready & bus.in_valid);
    advance  = transfer && (mode == MODE_RR);
`ifdef STREAM_MUX_RR_LOCK_EN
    lock     = !mux_last;
`else
    lock     = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
`ifdef STREAM_MUX_RR_LOCK_EN
      last_q  <= 1'b0;
`endif
    end else if (load_en) begin
      if (transfer) begin
        valid_q <= 1'b1;
        data_q  <= mux_data;
        chan_q  <= grant;
`ifdef STREAM_MUX_RR_LOCK_EN
        last_q  <= mux_last;
`endif
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_chan  = chan_q;
`ifdef STREAM_MUX_RR_LOCK_EN
  assign bus.out_last  = last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: vector table, corner sequences, random vs model.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int W = 8;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, mode3;
  logic [1:0] select, select3;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(W), .CHANNELS(4)) bus4 ();
  stream_mux_rr_if #(.WIDTH(W), .CHANNELS(3)) bus3 ();

  stream_mux_rr #(.WIDTH(W), .CHANNELS(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .select(select), .bus(bus4.slave));
  stream_mux_rr #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .select(select3), .bus(bus3.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output stage and arbitration history as plain variables.
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_chan;
  logic [1:0] m_last;
  logic       m_locked;
  logic [1:0] m_lock_ch;
  logic       m_olast;

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_chan = '0; m_last = 2'(C - 1);
    m_locked = 1'b0; m_lock_ch = '0; m_olast = 1'b0;
  endtask

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    logic [1:0] c;
    r = '0;
    if (m_valid && !bus4.out_ready) return r;
    if (mode == MODE_SELECT) begin
      r[select] = 1'b1;
      return r;
    end
    if (m_locked) begin
      if (bus4.in_valid[m_lock_ch]) r[m_lock_ch] = 1'b1;
      return r;
    end
    for (int k = 1; k <= C; k++) begin
      c = 2'((int'(m_last) + k) % C);
      if (bus4.in_valid[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic step4(output logic [3:0] acc_dut);
    logic [3:0]  er, vs, ls;
    logic [31:0] ds;
    logic        ms, ors;
    int          g;
    #1;
    er = model_ready();
    chk("rand in_ready", 32'(bus4.in_ready), 32'(er));
    acc_dut = bus4.in_ready & bus4.in_valid;
    vs = bus4.in_valid; ds = bus4.in_data; ms = mode; ors = bus4.out_ready;
`ifdef STREAM_MUX_RR_LOCK_EN
    ls = bus4.in_last;
`else
    ls = 4'hF;
`endif
    @(posedge clk); #1;
    if (!m_valid || ors) begin
      if ((er & vs) != 0) begin
        g = 0;
        for (int c = 0; c < C; c++) if (er[c] && vs[c]) g = c;
        m_valid = 1'b1;
        m_data  = ds[g*8 +: 8];
        m_chan  = 2'(g);
        m_olast = ls[g];
        if (ms == MODE_RR) begin
          if (!ls[g]) begin
            m_locked = 1'b1; m_lock_ch = 2'(g);
          end else begin
            m_locked = 1'b0; m_last = 2'(g);
          end
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    chk("rand out_valid", 32'(bus4.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rand out_data", 32'(bus4.out_data), 32'(m_data));
      chk("rand out_chan", 32'(bus4.out_chan), 32'(m_chan));
`ifdef STREAM_MUX_RR_LOCK_EN
      chk("rand out_last", 32'(bus4.out_last), 32'(m_olast));
`endif
    end
  endtask

  task automatic idle_inputs();
    bus4.in_valid = '0; bus3.in_valid = '0;
    bus4.out_ready = 1'b1; bus3.out_ready = 1'b1;
    mode = MODE_SELECT; mode3 = MODE_SELECT;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_chan;
  } vec_t;

  vec_t tv[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] acc;
    logic [3:0] prev_acc;

    tv[0]  = '{1'b0, 2'd2, 4'b0100, 32'h00A50000, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tv[1]  = '{1'b0, 2'd2, 4'b0000, 32'h00A50000, 4'b0100, 1'b0, 8'h00, 2'd0};
    tv[2]  = '{1'b0, 2'd0, 4'b1111, 32'h13121110, 4'b0001, 1'b1, 8'h10, 2'd0};
    tv[3]  = '{1'b0, 2'd3, 4'b0111, 32'h13121110, 4'b1000, 1'b0, 8'h00, 2'd0};
    tv[4]  = '{1'b0, 2'd1, 4'b0010, 32'h00003C00, 4'b0010, 1'b1, 8'h3C, 2'd1};
    tv[5]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 4'b0001, 1'b1, 8'h10, 2'd0};
    tv[6]  = '{1'b1, 2'd0, 4'b1010, 32'h23002100, 4'b0010, 1'b1, 8'h21, 2'd1};
    tv[7]  = '{1'b1, 2'd0, 4'b1010, 32'h23002100, 4'b1000, 1'b1, 8'h23, 2'd3};
    tv[8]  = '{1'b1, 2'd0, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'h00, 2'd0};
    tv[9]  = '{1'b1, 2'd0, 4'b0100, 32'h00770000, 4'b0100, 1'b1, 8'h77, 2'd2};
    tv[10] = '{1'b1, 2'd0, 4'b0001, 32'h00000088, 4'b0001, 1'b1, 8'h88, 2'd0};

    rst = 1'b1;
    select = '0; select3 = '0;
    bus4.in_data = '0; bus3.in_data = '0;
`ifdef STREAM_MUX_RR_LOCK_EN
    bus4.in_last = 4'hF; bus3.in_last = 3'h7;
`endif
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(bus4.out_valid), 32'd0);
    chk("reset out_data", 32'(bus4.out_data), 32'd0);
    chk("reset out_chan", 32'(bus4.out_chan), 32'd0);
    chk("reset out_valid ch3", 32'(bus3.out_valid), 32'd0);
`ifdef STREAM_MUX_RR_LOCK_EN
    chk("reset out_last", 32'(bus4.out_last), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table: out_ready held high, so each row's result depends only on the pointer.
    for (int i = 0; i < 11; i++) begin
      mode = tv[i].mode; select = tv[i].sel;
      bus4.in_valid = tv[i].valid; bus4.in_data = tv[i].data; bus4.out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(bus4.in_ready), 32'(tv[i].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 32'(bus4.out_valid), 32'(tv[i].exp_valid));
      if (tv[i].exp_valid) begin
        chk($sformatf("vec%0d out_data", i), 32'(bus4.out_data), 32'(tv[i].exp_data));
        chk($sformatf("vec%0d out_chan", i), 32'(bus4.out_chan), 32'(tv[i].exp_chan));
      end
    end

    // Round-robin throughput with all channels valid.
    do_reset();
    mode = MODE_RR; bus4.in_valid = 4'hF; bus4.in_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr in_ready", 32'(bus4.in_ready), 32'(1 << (k % 4)));
      @(posedge clk); #1;
      chk("rr out_valid", 32'(bus4.out_valid), 32'd1);
      chk("rr out_chan", 32'(bus4.out_chan), 32'(k % 4));
      chk("rr out_data", 32'(bus4.out_data), 32'(8'h10 + 8'(k % 4)));
    end

    // Backpressure: held beat from channel 0 stays put.
    bus4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp in_ready", 32'(bus4.in_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp out_valid", 32'(bus4.out_valid), 32'd1);
      chk("bp out_data", 32'(bus4.out_data), 32'h10);
      chk("bp out_chan", 32'(bus4.out_chan), 32'd0);
    end
    bus4.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(bus4.in_ready), 32'b0010);
    @(posedge clk); #1;
    chk("bp release out_chan", 32'(bus4.out_chan), 32'd1);
    chk("bp release out_data", 32'(bus4.out_data), 32'h11);
    @(posedge clk); #1;
    chk("pre-reset out_chan", 32'(bus4.out_chan), 32'd2);

    // Asynchronous reset mid-cycle while a beat is held.
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(bus4.out_valid), 32'd0);
    chk("async rst out_chan", 32'(bus4.out_chan), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    mode = MODE_RR; bus4.in_valid = 4'hF; bus4.in_data = 32'h13121110;
    #1;
    chk("post rst in_ready", 32'(bus4.in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post rst out_chan", 32'(bus4.out_chan), 32'd0);
    chk("post rst out_valid", 32'(bus4.out_valid), 32'd1);

    // Three-channel instance: out-of-range select grants nobody.
    select3 = 2'd1; bus3.in_valid = 3'b010; bus3.in_data = 24'h005500; bus3.out_ready = 1'b1;
    #1;
    chk("c3 sel1 in_ready", 32'(bus3.in_ready), 32'b010);
    @(posedge clk); #1;
    chk("c3 sel1 out_data", 32'(bus3.out_data), 32'h55);
    chk("c3 sel1 out_chan", 32'(bus3.out_chan), 32'd1);
    select3 = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b0;
    #1;
    chk("c3 oor held in_ready", 32'(bus3.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("c3 oor held out_valid", 32'(bus3.out_valid), 32'd1);
    bus3.out_ready = 1'b1;
    #1;
    chk("c3 oor drain in_ready", 32'(bus3.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("c3 oor drain out_valid", 32'(bus3.out_valid), 32'd0);

`ifdef STREAM_MUX_RR_LOCK_EN
    // Packet lock: channel 1 sends three beats while channels 0 and 2 wait.
    do_reset();
    mode = MODE_RR; bus4.in_data = 32'h13121110;
    bus4.in_last = 4'b1101; bus4.in_valid = 4'b0001;
    @(posedge clk); #1;
    chk("lock pre out_chan", 32'(bus4.out_chan), 32'd0);
    bus4.in_valid = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) bus4.in_last = 4'b1111;
      if (k == 3) bus4.in_valid = 4'b0101;
      @(posedge clk); #1;
      chk($sformatf("lock beat%0d out_chan", k), 32'(bus4.out_chan),
          (k < 3) ? 32'd1 : (k == 3) ? 32'd2 : 32'd0);
      if (k < 3)
        chk($sformatf("lock beat%0d out_last", k), 32'(bus4.out_last), (k == 2) ? 32'd1 : 32'd0);
    end
    bus4.in_last = 4'hF;
`endif

    // Randomized traffic against the model.
    do_reset();
    prev_acc = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < C; c++) begin
        if (prev_acc[c]) bus4.in_valid[c] = 1'b0;
        if (!bus4.in_valid[c] && $urandom_range(1, 0) == 1) begin
          bus4.in_valid[c] = 1'b1;
          bus4.in_data[c*8 +: 8] = 8'($urandom());
`ifdef STREAM_MUX_RR_LOCK_EN
          bus4.in_last[c] = ($urandom_range(2, 0) != 0);
`endif
        end
      end
      if ($urandom_range(15, 0) == 0) mode = ~mode;
      if ($urandom_range(3, 0) == 0) select = 2'($urandom_range(3, 0));
      bus4.out_ready = ($urandom_range(9, 0) < 7);
      step4(acc);
      prev_acc = acc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
